pop_serializer: RTL and testbench
=================================

Name: pop_serializer

Overview:
- Transmit-side partner of the bit-serial popcount receiver. It accepts one pop_size-bit word over a valid/ready handshake and emits it MSB first, one bit per cycle, on a single-bit stream.
- Bit order is fixed: after pop_size consecutive transfers, a downstream left-shifting register (new bit entering at LSB) holds exactly the loaded word.
- In parallel it computes the golden popcount of the word, or the majority-of-3 count when enabled. Benches use this value to check the receiver; frequency harnesses use it as a traffic source.

Parameters:
- Majority_enable, 0, 1 = reference count is the number of 3-bit groups with at least two ones; 0 = plain popcount.
- pop_size, 576, word width in bits; must be a multiple of 3 when Majority_enable = 1.
- maj_size, pop_size/3, number of majority groups.
- cnt_size, Majority_enable ? $clog2(maj_size+1) : $clog2(pop_size+1), width of the reference count. The +1 is required so the all-ones word does not overflow.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  word available on in_word.
- in_ready  out  1  block can accept a word this cycle.
- in_word  in  pop_size  parallel word to transmit.
- out_ready  in  1  downstream accepts a bit this cycle.
- bit_valid  out  1  bit_out is valid.
- bit_out  out  1  serial data, MSB of the word first.
- bit_last  out  1  high with the final (LSB) bit of a word.
- ref_valid  out  1  one-cycle pulse: ref_pop has been updated.
- ref_pop  out  cnt_size  reference count of the last completed word.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high, and wins over all other inputs.
- Reset values: state IDLE; bit counter 0; shift register 0; accumulator 0; bit_valid 0; bit_last 0; ref_valid 0; ref_pop 0. in_ready reads 1 in the first cycle after reset.
- State IDLE:
  - in_ready = 1, bit_valid = 0.
  - When in_valid = 1: load in_word, clear the counter and accumulator, go to SHIFT.
  - The first bit is presented in the next cycle (load-to-first-bit latency 1).
- State SHIFT:
  - bit_valid = 1 and bit_out = shift register MSB.
  - bit_last = 1 when the counter equals pop_size-1.
  - A bit transfers on bit_valid && out_ready. On transfer: shift left by one, increment the counter, update the accumulator.
  - When out_ready = 0: the bit, counter and accumulator hold; bit_valid stays 1 and the bit stays stable.
- End of word:
  - The last bit's transfer sets ref_pop to the final count (including that bit) and pulses ref_valid in the next cycle.
  - ref_pop then holds until the next pulse.
- Back-to-back:
  - in_ready = 1 during SHIFT only in the cycle where the last bit transfers.
  - If in_valid is also 1 in that cycle, the new word loads and its MSB is presented the next cycle, so the stream has no bubble.
  - Otherwise the block returns to IDLE.
- Plain mode: the accumulator adds bit_out on every transfer.
- Majority mode:
  - A mod-3 group counter and a 2-bit in-group ones count are maintained.
  - On the third bit of a group: the accumulator increments if (ones + current bit) >= 2, then the group state clears.
- Arithmetic: the accumulator is cnt_size wide and cannot overflow given the cnt_size definition.
- in_word is sampled only at load; changes at any other time are ignored.
- Reset mid-word: the word is discarded and no ref_valid pulse is issued for it.

Decomposition:
- Shared package: the state encoding (IDLE, SHIFT) and a width function so that receiver and transmitter agree on count widths. The function must offer two variants:
  - $clog2(n+1), used by this block.
  - $clog2(n), the receiver's legacy width. The receiver is unchanged by this spec; the bench compares against it within its width.
- One natural sub-module: pop_ref_acc, the plain/majority accumulator with inputs bit, strobe, clear and output count. It is reusable in the receiver's bench.

Test Plan (pop_size = 6 unless noted):
- Reset then load 6'b101100, out_ready = 1:
  - bit_out = 1,0,1,1,0,0 on cycles 1-6; bit_last on cycle 6.
  - ref_valid pulses on cycle 7 with ref_pop = 3.
- Majority_enable = 1, word 6'b110001:
  - groups 110 -> 1 and 001 -> 0, so ref_pop = 1.
  - word 6'b111111: ref_pop = 2.
- Plain mode, word 6'b111111: ref_pop = 6 (no overflow; cnt_size = 3).
  - pop_size = 8, all-ones word: ref_pop = 8 with cnt_size = 4.
- Back-to-back:
  - in_valid held high with words 6'b100000 then 6'b000001.
  - in_ready is high exactly in the cycle of the first word's last bit.
  - 12 contiguous bit_valid cycles, ref_pop = 1 then 1.
- Stall: out_ready low for 3 cycles after bit 2.
  - bit_out is stable and bit_valid stays high during the stall.
  - ref_pop is unchanged versus the no-stall run.
- Reset asserted after bit 3 of a word:
  - next cycle bit_valid = 0, in_ready = 1, ref_pop = 0.
  - no ref_valid pulse for the aborted word.

Source files
------------

// File: rtl/pop_serializer_pkg.sv
// Shared definitions for the bit-serial popcount transmitter and its receiver:
// FSM state encoding and the count-width helper both sides size their counters with.
package pop_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pop_state_t;

  typedef enum logic {
    WIDTH_FULL   = 1'b0,
    WIDTH_LEGACY = 1'b1
  } width_kind_t;

  // FULL leaves room for the all-ones count; LEGACY is the receiver's original sizing.
  function automatic int cnt_width(input int n, input width_kind_t kind = WIDTH_FULL);
    return (kind == WIDTH_LEGACY) ? $clog2(n) : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pop_ref_acc.sv
// Reference accumulator: plain popcount or count of 3-bit groups holding at least two ones.
// count already includes a bit strobed this cycle, so a caller can capture the final total.
module pop_ref_acc
  import pop_serializer_pkg::*;
#(
  parameter bit Majority_enable = 1'b0,
  parameter int cnt_size        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                strobe,
  input  logic                bit_in,
  output logic [cnt_size-1:0] count
);

  logic                inc;
  logic [cnt_size-1:0] acc_q;

  generate
    if (Majority_enable) begin : g_maj
      logic [1:0] grp_idx;
      logic [1:0] ones;
      logic [2:0] ones_sum;

      assign ones_sum = {1'b0, ones} + {2'b00, bit_in};
      assign inc      = strobe && (grp_idx == 2'd2) && (ones_sum >= 3'd2);

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          grp_idx <= 2'd0;
          ones    <= 2'd0;
        end else if (strobe) begin
          if (grp_idx == 2'd2) begin
            grp_idx <= 2'd0;
            ones    <= 2'd0;
          end else begin
            grp_idx <= grp_idx + 2'd1;
            // at most two ones are seen before the third bit, so this cannot wrap
            ones    <= ones_sum[1:0];
          end
        end
      end
    end else begin : g_plain
      assign inc = strobe && bit_in;
    end
  endgenerate

  assign count = acc_q + cnt_size'(inc);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) acc_q <= '0;
    else                acc_q <= count;
  end

endmodule

// File: rtl/pop_serializer.sv
// Word-to-bit serializer, MSB first, with a golden popcount/majority reference
// for checking the bit-serial popcount receiver.
module pop_serializer
  import pop_serializer_pkg::*;
#(
  parameter bit Majority_enable = 1'b0,
  parameter int pop_size        = 576,
  parameter int maj_size        = pop_size / 3,
  parameter int cnt_size        = Majority_enable ? cnt_width(maj_size) : cnt_width(pop_size)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [pop_size-1:0] in_word,
  input  logic                out_ready,
  output logic                bit_valid,
  output logic                bit_out,
  output logic                bit_last,
  output logic                ref_valid,
  output logic [cnt_size-1:0] ref_pop
);

  localparam int               idx_w    = (pop_size > 1) ? $clog2(pop_size) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(pop_size - 1);

  pop_state_t          state;
  logic [pop_size-1:0] shreg;
  logic [idx_w-1:0]    bit_cnt;
  logic                at_last;
  logic                xfer;
  logic                load;
  logic [cnt_size-1:0] acc_count;

  assign at_last   = (bit_cnt == last_idx);
  assign xfer      = bit_valid && out_ready;
  // Accepting during the final transfer lets the next word follow with no bubble.
  assign in_ready  = (state == IDLE) || (xfer && at_last);
  assign load      = in_valid && in_ready;
  assign bit_out   = shreg[pop_size-1];
  assign bit_last  = bit_valid && at_last;

  pop_ref_acc #(
    .Majority_enable(Majority_enable),
    .cnt_size       (cnt_size)
  ) u_ref_acc (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .strobe(xfer),
    .bit_in(bit_out),
    .count (acc_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      bit_valid <= 1'b0;
      ref_valid <= 1'b0;
      ref_pop   <= '0;
    end else begin
      ref_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg     <= in_word;
            bit_cnt   <= '0;
            bit_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + idx_w'(1);
            if (at_last) begin
              ref_pop   <= acc_count;
              ref_valid <= 1'b1;
              if (in_valid) begin
                shreg     <= in_word;
                bit_cnt   <= '0;
                bit_valid <= 1'b1;
                state     <= SHIFT;
              end else begin
                bit_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: begin
          bit_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pop_serializer.sv
// Scoreboard bench: plain and majority 6-bit serializers plus a plain 8-bit one,
// each checked against a popcount/majority model computed from the loaded words.
module tb_pop_serializer;
  import pop_serializer_pkg::*;

  localparam int CW_P = cnt_width(6);
  localparam int CW_M = cnt_width(2);
  localparam int CW_W = cnt_width(8);

  typedef struct {
    logic [7:0] word;
    int         ref_cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid6, in_valid8;
  logic [5:0]      in_word6;
  logic [7:0]      in_word8;
  logic            forced_ready, rand_ready, rnd_ready;
  logic            out_ready;
  logic [2:0]      ir, bv, bo, bl, rv;
  logic [CW_P-1:0] rp0;
  logic [CW_M-1:0] rp1;
  logic [CW_W-1:0] rp2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int         nbits   [3];
  logic [7:0] rx      [3];
  bit         pend    [3];
  int         pend_ref[3];
  bit         stall   [3];
  logic       prev_bit[3];

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_ready : forced_ready;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  pop_serializer #(.Majority_enable(1'b0), .pop_size(6)) dut_p (
    .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(ir[0]), .in_word(in_word6),
    .out_ready(out_ready), .bit_valid(bv[0]), .bit_out(bo[0]), .bit_last(bl[0]),
    .ref_valid(rv[0]), .ref_pop(rp0));

  pop_serializer #(.Majority_enable(1'b1), .pop_size(6)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(ir[1]), .in_word(in_word6),
    .out_ready(out_ready), .bit_valid(bv[1]), .bit_out(bo[1]), .bit_last(bl[1]),
    .ref_valid(rv[1]), .ref_pop(rp1));

  pop_serializer #(.Majority_enable(1'b0), .pop_size(8)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir[2]), .in_word(in_word8),
    .out_ready(out_ready), .bit_valid(bv[2]), .bit_out(bo[2]), .bit_last(bl[2]),
    .ref_valid(rv[2]), .ref_pop(rp2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain popcount, or number of 3-bit groups with two or more ones.
  function automatic int model_ref(input logic [7:0] w, input int n, input bit maj);
    int total = 0;
    if (!maj) begin
      for (int i = 0; i < n; i++) total += int'(w[i]);
    end else begin
      for (int g = 0; g < n / 3; g++)
        if (int'(w[3*g]) + int'(w[3*g+1]) + int'(w[3*g+2]) >= 2) total++;
    end
    return total;
  endfunction

  function automatic int get_rp(input int k);
    case (k)
      0:       return int'(rp0);
      1:       return int'(rp1);
      default: return int'(rp2);
    endcase
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t sb_pop(input int k);
    case (k)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  function automatic void push_word(input int k, input logic [7:0] w);
    exp_t e;
    e.word = w;
    if (k == 0) begin
      e.word    = {2'b00, w[5:0]};
      e.ref_cnt = model_ref(e.word, 6, 1'b0);
      sb0.push_back(e);
      e.ref_cnt = model_ref(e.word, 6, 1'b1);
      sb1.push_back(e);
    end else begin
      e.ref_cnt = model_ref(w, 8, 1'b0);
      sb2.push_back(e);
    end
  endfunction

  // Monitor: rebuilds each word with a left shift, checks it and the following ref pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int         sz;
      logic [7:0] mask;
      exp_t       e;
      sz   = (k == 2) ? 8 : 6;
      mask = (k == 2) ? 8'hFF : 8'h3F;
      if (reset) begin
        nbits[k] = 0;
        rx[k]    = '0;
        pend[k]  = 1'b0;
        stall[k] = 1'b0;
        if (k == 0) sb0.delete();
        if (k == 1) sb1.delete();
        if (k == 2) sb2.delete();
      end else begin
        if (pend[k]) begin
          check($sformatf("ref_valid_pulse_dut%0d", k), rv[k], 1);
          check($sformatf("ref_pop_dut%0d", k), get_rp(k), pend_ref[k]);
          pend[k] = 1'b0;
        end else if (rv[k]) begin
          check($sformatf("spurious_ref_valid_dut%0d", k), rv[k], 0);
        end
        if (stall[k]) begin
          check($sformatf("stall_valid_dut%0d", k), bv[k], 1);
          check($sformatf("stall_bit_stable_dut%0d", k), bo[k], prev_bit[k]);
        end
        stall[k]    = bv[k] && !out_ready;
        prev_bit[k] = bo[k];
        if (bv[k] && out_ready) begin
          rx[k] = {rx[k][6:0], bo[k]};
          nbits[k]++;
          check($sformatf("bit_last_dut%0d", k), bl[k], (nbits[k] == sz));
          if (nbits[k] == sz) begin
            if (sb_size(k) == 0) begin
              check($sformatf("word_without_load_dut%0d", k), sb_size(k), 1);
            end else begin
              e = sb_pop(k);
              check($sformatf("word_dut%0d", k), rx[k] & mask, e.word);
              pend_ref[k] = e.ref_cnt;
              pend[k]     = 1'b1;
            end
            nbits[k] = 0;
            rx[k]    = '0;
          end
        end
      end
    end
  end

  // Present a word from posedge+1 and return at posedge+1 after it was accepted.
  task automatic load(input int k, input logic [7:0] w, input bit keep_valid);
    bit got = 1'b0;
    if (k == 0) begin in_valid6 = 1'b1; in_word6 = w[5:0]; end
    else        begin in_valid8 = 1'b1; in_word8 = w;      end
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      got = (k == 0) ? ir[0] : ir[2];
    end
    if (!got) check("in_ready_timeout", (k == 0) ? ir[0] : ir[2], 1);
    @(posedge clk);
    if (got) push_word(k, w);
    #1;
    if (!keep_valid || !got) begin
      if (k == 0) in_valid6 = 1'b0;
      else        in_valid8 = 1'b0;
    end
  endtask

  task automatic wait_ref6(input int exp_plain, input int exp_maj, input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      seen = rv[0];
    end
    check({tag, "_ref_valid"}, rv[0], 1);
    check({tag, "_plain_ref_pop"}, get_rp(0), exp_plain);
    check({tag, "_maj_ref_valid"}, rv[1], 1);
    check({tag, "_maj_ref_pop"}, get_rp(1), exp_maj);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (sb0.size() == 0) && (sb1.size() == 0) && (sb2.size() == 0) &&
             !pend[0] && !pend[1] && !pend[2] && bv == 3'b000;
    end
    check({tag, "_drained"}, done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] w6;
    logic [7:0] w8;
    int         gap;
    bit         keep;

    reset = 1'b1; in_valid6 = 1'b0; in_valid8 = 1'b0; in_word6 = '0; in_word8 = '0;
    forced_ready = 1'b1; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_%0d", k), ir[k], 1);
      check($sformatf("rst_bit_valid_%0d", k), bv[k], 0);
      check($sformatf("rst_bit_last_%0d", k), bl[k], 0);
      check($sformatf("rst_ref_valid_%0d", k), rv[k], 0);
      check($sformatf("rst_ref_pop_%0d", k), get_rp(k), 0);
    end
    @(posedge clk);
    #1;

    // 101100: MSB-first bits on cycles 1..6, ref pulse on cycle 7
    w6 = 6'b101100;
    load(0, {2'b00, w6}, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("seq_valid_c%0d", c), bv[0], 1);
      check($sformatf("seq_bit_c%0d", c), bo[0], w6[6-c]);
      check($sformatf("seq_last_c%0d", c), bl[0], (c == 6));
    end
    @(negedge clk);
    check("seq_ref_valid_c7", rv[0], 1);
    check("seq_ref_pop_c7", get_rp(0), 3);
    check("seq_idle_c7", bv[0], 0);
    @(posedge clk);
    #1;

    // Majority groups and the all-ones word
    load(0, 8'b00110001, 1'b0);
    wait_ref6(3, 1, "w110001");
    load(0, 8'b00111111, 1'b0);
    wait_ref6(6, 2, "w111111");

    // Back-to-back: in_valid stays high across two words
    load(0, 8'b00100000, 1'b1);
    in_word6 = 6'b000001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_c%0d", c), bv[0], 1);
      check($sformatf("b2b_in_ready_c%0d", c), ir[0], (c % 6 == 0));
      if (c == 7) begin
        check("b2b_first_ref_valid", rv[0], 1);
        check("b2b_first_ref_pop", get_rp(0), 1);
      end
      if (c == 6) begin
        @(posedge clk);
        if (ir[0]) push_word(0, 8'b00000001);
        #1 in_valid6 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_after", bv[0], 0);
    check("b2b_second_ref_valid", rv[0], 1);
    check("b2b_second_ref_pop", get_rp(0), 1);
    @(posedge clk);
    #1;

    // Stall for 3 cycles after two bits have gone
    w6 = 6'b101100;
    load(0, {2'b00, w6}, 1'b0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 forced_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall_valid_s%0d", s), bv[0], 1);
      check($sformatf("stall_bit_s%0d", s), bo[0], w6[3]);
    end
    @(posedge clk);
    #1 forced_ready = 1'b1;
    wait_ref6(3, 1, "stall");

    // Reset after three bits of a word: word dropped, no ref pulse
    load(0, 8'b00110001, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_bit_valid", bv[0], 0);
    check("abort_in_ready", ir[0], 1);
    check("abort_ref_pop", get_rp(0), 0);
    check("abort_maj_ref_pop", get_rp(1), 0);
    for (int c = 0; c < 8; c++) begin
      check("abort_no_ref_valid", rv[0], 0);
      check("abort_no_maj_ref_valid", rv[1], 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Random words, random gaps and back-to-back, random downstream backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w6   = 6'($urandom);
      gap  = $urandom_range(0, 2);
      keep = (gap == 0) && (i < 29);
      load(0, {2'b00, w6}, keep);
      if (!keep) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    drain("rand6");
    rand_ready = 1'b0;

    // 8-bit plain: all-ones must count to 8 without overflow
    load(2, 8'hFF, 1'b0);
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
        @(negedge clk);
        seen = rv[2];
      end
      check("w8_all_ones_ref_valid", rv[2], 1);
      check("w8_all_ones_ref_pop", get_rp(2), 8);
    end
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w8 = 8'($urandom);
      load(2, w8, ($urandom_range(0, 1) == 1) && (i < 11));
    end
    drain("rand8");
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
